xbus_arbiter: RTL and testbench

//   Shares the single xbus between NM masters (e.g. I-fetch, LSU, debug) using round-robin arbitration.

---
 rtl/xbus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_xbus_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/xbus_arbiter.sv
// Round-robin arbiter and transfer sequencer placing one of NM masters on the xbus.
// Each transfer runs IDLE -> BUSY -> RESP. Unmapped addresses and slave timeouts end with an error response.
module xbus_arbiter #(
    parameter int NM      = 2,
    parameter int NS      = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NM-1:0]    m_req,
    input  logic [NM*32-1:0] m_addr,
    input  logic [NM*32-1:0] m_wdata,
    input  logic [NM-1:0]    m_we,
    output logic [NM-1:0]    m_gnt,
    output logic [NM-1:0]    m_ack,
    output logic             m_err,
    output logic [31:0]      m_rdata,
    output logic             xbus_as,
    output logic [31:0]      xbus_addr,
    output logic [31:0]      xbus_wdata,
    output logic             xbus_we,
    input  logic [NS-1:0]    xbus_cs,
    input  logic             xbus_ready,
    input  logic [31:0]      xbus_rdata
);

    localparam int IW = (NM > 1) ? $clog2(NM) : 1;
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [IW-1:0]   gnt_idx_reg, gnt_idx_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [NM-1:0]   m_gnt_reg, m_gnt_next;
    logic [NM-1:0]   m_ack_reg, m_ack_next;
    logic            m_err_reg, m_err_next;
    logic [31:0]     m_rdata_reg, m_rdata_next;
    logic            xbus_as_reg, xbus_as_next;
    logic [31:0]     xbus_addr_reg, xbus_addr_next;
    logic [31:0]     xbus_wdata_reg, xbus_wdata_next;
    logic            xbus_we_reg, xbus_we_next;

    logic [IW-1:0]   pick_idx;
    logic [IW:0]     cand;
    logic [NM-1:0]   pick_onehot;

    // Scan downward so the requester closest to rr_ptr (lowest offset) wins last.
    always_comb begin
        pick_idx = rr_ptr_reg;
        cand     = '0;
        for (int k = NM - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_reg} + (IW+1)'(k);
            if (cand >= (IW+1)'(NM))
                cand = cand - (IW+1)'(NM);
            if (m_req[cand[IW-1:0]])
                pick_idx = cand[IW-1:0];
        end
    end

    generate
        for (genvar gi = 0; gi < NM; gi++) begin : g_onehot
            assign pick_onehot[gi] = (pick_idx == IW'(gi));
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        rr_ptr_next     = rr_ptr_reg;
        gnt_idx_next    = gnt_idx_reg;
        cnt_next        = cnt_reg;
        m_gnt_next      = m_gnt_reg;
        m_ack_next      = '0;
        m_err_next      = m_err_reg;
        m_rdata_next    = m_rdata_reg;
        xbus_as_next    = xbus_as_reg;
        xbus_addr_next  = xbus_addr_reg;
        xbus_wdata_next = xbus_wdata_reg;
        xbus_we_next    = xbus_we_reg;

        case (state_reg)
            IDLE: begin
                if (|m_req) begin
                    gnt_idx_next    = pick_idx;
                    m_gnt_next      = pick_onehot;
                    xbus_addr_next  = m_addr[32*pick_idx +: 32];
                    xbus_wdata_next = m_wdata[32*pick_idx +: 32];
                    xbus_we_next    = m_we[pick_idx];
                    xbus_as_next    = 1'b1;
                    cnt_next        = '0;
                    state_next      = BUSY;
                end
            end
            BUSY: begin
                cnt_next = cnt_reg + 1'b1;
                if (xbus_cs == '0) begin
                    m_err_next   = 1'b1;
                    m_rdata_next = '0;
                    m_ack_next   = m_gnt_reg;
                    xbus_as_next = 1'b0;
                    state_next   = RESP;
                end else if (xbus_ready) begin
                    m_err_next   = 1'b0;
                    m_rdata_next = xbus_we_reg ? 32'h0 : xbus_rdata;
                    m_ack_next   = m_gnt_reg;
                    xbus_as_next = 1'b0;
                    state_next   = RESP;
                end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                    m_err_next   = 1'b1;
                    m_rdata_next = '0;
                    m_ack_next   = m_gnt_reg;
                    xbus_as_next = 1'b0;
                    state_next   = RESP;
                end
            end
            RESP: begin
                m_gnt_next   = '0;
                m_err_next   = 1'b0;
                m_rdata_next = '0;
                cnt_next     = '0;
                rr_ptr_next  = (gnt_idx_reg == IW'(NM - 1)) ? '0 : gnt_idx_reg + 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            rr_ptr_reg     <= '0;
            gnt_idx_reg    <= '0;
            cnt_reg        <= '0;
            m_gnt_reg      <= '0;
            m_ack_reg      <= '0;
            m_err_reg      <= 1'b0;
            m_rdata_reg    <= '0;
            xbus_as_reg    <= 1'b0;
            xbus_addr_reg  <= '0;
            xbus_wdata_reg <= '0;
            xbus_we_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rr_ptr_reg     <= rr_ptr_next;
            gnt_idx_reg    <= gnt_idx_next;
            cnt_reg        <= cnt_next;
            m_gnt_reg      <= m_gnt_next;
            m_ack_reg      <= m_ack_next;
            m_err_reg      <= m_err_next;
            m_rdata_reg    <= m_rdata_next;
            xbus_as_reg    <= xbus_as_next;
            xbus_addr_reg  <= xbus_addr_next;
            xbus_wdata_reg <= xbus_wdata_next;
            xbus_we_reg    <= xbus_we_next;
        end
    end

    assign m_gnt      = m_gnt_reg;
    assign m_ack      = m_ack_reg;
    assign m_err      = m_err_reg;
    assign m_rdata    = m_rdata_reg;
    assign xbus_as    = xbus_as_reg;
    assign xbus_addr  = xbus_addr_reg;
    assign xbus_wdata = xbus_wdata_reg;
    assign xbus_we    = xbus_we_reg;

endmodule

// File: tb/tb_xbus_arbiter.sv
// Directed bench for xbus_arbiter: read, unmapped, timeout, write, reset abort and round-robin sequences.
module tb_xbus_arbiter;

    localparam int NM = 2;
    localparam int NS = 4;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NM-1:0]    m_req;
    logic [NM*32-1:0] m_addr;
    logic [NM*32-1:0] m_wdata;
    logic [NM-1:0]    m_we;
    logic [NM-1:0]    m_gnt;
    logic [NM-1:0]    m_ack;
    logic             m_err;
    logic [31:0]      m_rdata;
    logic             xbus_as;
    logic [31:0]      xbus_addr;
    logic [31:0]      xbus_wdata;
    logic             xbus_we;
    logic [NS-1:0]    xbus_cs;
    logic             xbus_ready;
    logic [31:0]      xbus_rdata;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int busy;

    always #5 clk = ~clk;

    // Decoder: bit31, bit16 and bit12 regions are mapped; anything else selects no slave.
    assign xbus_cs = xbus_as ? {xbus_addr[31], xbus_addr[16], xbus_addr[12], 1'b0} : '0;

    xbus_arbiter #(.NM(NM), .NS(NS), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .m_req      (m_req),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_we       (m_we),
        .m_gnt      (m_gnt),
        .m_ack      (m_ack),
        .m_err      (m_err),
        .m_rdata    (m_rdata),
        .xbus_as    (xbus_as),
        .xbus_addr  (xbus_addr),
        .xbus_wdata (xbus_wdata),
        .xbus_we    (xbus_we),
        .xbus_cs    (xbus_cs),
        .xbus_ready (xbus_ready),
        .xbus_rdata (xbus_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; m_req = '0; m_addr = '0; m_wdata = '0; m_we = '0;
        xbus_ready = 1'b0; xbus_rdata = '0;
        step(); step();
        chk("rst_as",    32'(xbus_as), 32'd0);
        chk("rst_gnt",   32'(m_gnt),   32'd0);
        chk("rst_ack",   32'(m_ack),   32'd0);
        chk("rst_err",   32'(m_err),   32'd0);
        chk("rst_rdata", m_rdata,      32'd0);
        chk("rst_addr",  xbus_addr,    32'd0);
        rst = 1'b0;
        step();

        // Single read by m0, slave ready on the first BUSY cycle
        m_req = 2'b01; m_addr[31:0] = 32'h8000_0010; m_we = 2'b00;
        step();
        chk("rd_as",   32'(xbus_as), 32'd1);
        chk("rd_gnt",  32'(m_gnt),   32'd1);
        chk("rd_addr", xbus_addr,    32'h8000_0010);
        chk("rd_we",   32'(xbus_we), 32'd0);
        chk("rd_noack", 32'(m_ack),  32'd0);
        xbus_ready = 1'b1; xbus_rdata = 32'hDEAD_BEEF;
        step();
        chk("rd_ack",   32'(m_ack),   32'd1);
        chk("rd_err",   32'(m_err),   32'd0);
        chk("rd_rdata", m_rdata,      32'hDEAD_BEEF);
        chk("rd_as_lo", 32'(xbus_as), 32'd0);
        m_req = '0; xbus_ready = 1'b0;
        step();
        chk("rd_ack_1cyc", 32'(m_ack), 32'd0);
        chk("rd_gnt_clr",  32'(m_gnt), 32'd0);
        $display("txn single_read done");

        // Unmapped read by m1
        m_req = 2'b10; m_addr[63:32] = 32'h0000_2000;
        step();
        chk("um_gnt", 32'(m_gnt),   32'd2);
        chk("um_as",  32'(xbus_as), 32'd1);
        step();
        chk("um_ack",   32'(m_ack), 32'd2);
        chk("um_err",   32'(m_err), 32'd1);
        chk("um_rdata", m_rdata,    32'd0);
        m_req = '0;
        step();
        $display("txn unmapped done");

        // Timeout: m0 reads a mapped address, slave never ready
        m_req = 2'b01; m_addr[31:0] = 32'h0000_1000; xbus_rdata = 32'h1111_2222;
        busy = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (xbus_as) busy++;
            if (m_ack != '0) break;
        end
        chk("to_busy",  32'(busy),  32'd16);
        chk("to_ack",   32'(m_ack), 32'd1);
        chk("to_err",   32'(m_err), 32'd1);
        chk("to_rdata", m_rdata,    32'd0);
        m_req = '0;
        step();
        $display("txn timeout done");

        // Ready arriving on the final BUSY cycle beats the timeout
        m_req = 2'b01; xbus_rdata = 32'hCAFE_F00D;
        busy = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            step();
            if (xbus_as) busy++;
            if (i == TIMEOUT - 1) xbus_ready = 1'b1;
        end
        step();
        chk("tr_busy",  32'(busy),  32'd16);
        chk("tr_ack",   32'(m_ack), 32'd1);
        chk("tr_err",   32'(m_err), 32'd0);
        chk("tr_rdata", m_rdata,    32'hCAFE_F00D);
        m_req = '0; xbus_ready = 1'b0;
        step();
        $display("txn timeout_ready done");

        // Write by m0; master-side inputs change during BUSY but the bus stays latched
        m_req = 2'b01; m_addr[31:0] = 32'h0001_0000; m_wdata[31:0] = 32'h1234_5678; m_we = 2'b01;
        step();
        chk("wr_we",    32'(xbus_we), 32'd1);
        chk("wr_wdata", xbus_wdata,   32'h1234_5678);
        chk("wr_addr",  xbus_addr,    32'h0001_0000);
        m_req = '0; m_wdata[31:0] = 32'h0; m_we = 2'b00; m_addr[31:0] = 32'h0;
        step();
        chk("wr_wdata_hold", xbus_wdata,   32'h1234_5678);
        chk("wr_we_hold",    32'(xbus_we), 32'd1);
        chk("wr_as_hold",    32'(xbus_as), 32'd1);
        xbus_ready = 1'b1; xbus_rdata = 32'hFFFF_FFFF;
        step();
        chk("wr_ack",   32'(m_ack), 32'd1);
        chk("wr_err",   32'(m_err), 32'd0);
        chk("wr_rdata", m_rdata,    32'd0);
        xbus_ready = 1'b0;
        step();
        $display("txn write done");

        // Reset in the middle of a BUSY transfer by m1
        m_req = 2'b10; m_addr[63:32] = 32'h8000_0000;
        step();
        chk("rb_gnt", 32'(m_gnt), 32'd2);
        rst = 1'b1; m_req = '0;
        step();
        chk("rb_as",    32'(xbus_as), 32'd0);
        chk("rb_gnt0",  32'(m_gnt),   32'd0);
        chk("rb_ack",   32'(m_ack),   32'd0);
        chk("rb_addr0", xbus_addr,    32'd0);
        rst = 1'b0;
        step();
        chk("rb_noack", 32'(m_ack), 32'd0);
        $display("txn reset_abort done");

        // Round-robin: both masters request continuously, slave always ready
        m_req = 2'b11; m_we = 2'b00;
        m_addr[31:0] = 32'h8000_0010; m_addr[63:32] = 32'h0001_0000;
        xbus_ready = 1'b1; xbus_rdata = 32'h55AA_55AA;
        for (int t = 0; t < 4; t++) begin
            step();
            chk("rr_gnt", 32'(m_gnt), ((t % 2) == 0) ? 32'd1 : 32'd2);
            chk("rr_busy_noack", 32'(m_ack), 32'd0);
            step();
            chk("rr_ack", 32'(m_ack), ((t % 2) == 0) ? 32'd1 : 32'd2);
            chk("rr_rdata", m_rdata, 32'h55AA_55AA);
            step();
            chk("rr_idle_gnt", 32'(m_gnt), 32'd0);
            $display("txn round_robin grant %0d done", t);
        end
        m_req = '0; xbus_ready = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
